// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types: opcode constants, the immediate-format select used by
// the sign-extender, and the fetch FSM state encoding.
package rv_fetch_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_src_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imm_src_decode.sv
// Combinational opcode -> immediate-format select, encoded as the sign-extender's src input.
module imm_src_decode
    import rv_fetch_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_src_t   imm_src
);

    // Opcodes without an immediate (or with U-type) fall back to IMM_I.
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_src = IMM_I;
            OPC_STORE:                     imm_src = IMM_S;
            OPC_BRANCH:                    imm_src = IMM_B;
            OPC_JAL:                       imm_src = IMM_J;
            default:                       imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Single-outstanding instruction fetch stage with redirect/drop handling.
// Optional feature macro: MISALIGN_CHECK_EN (adds if_misaligned, keeps redirect_pc[1:0]).
module instr_fetch_stage
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [1:0]  if_imm_src
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        if_misaligned
`endif
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic         drop_r;
    imm_src_t     dec_imm_s;
    logic [31:0]  redir_pc_s;

`ifdef MISALIGN_CHECK_EN
    logic         mis_pend_r;
    assign redir_pc_s = redirect_pc;
`else
    logic         unused_redir_lsb_s;
    assign redir_pc_s         = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb_s = ^redirect_pc[1:0];
`endif

    imm_src_decode u_imm_src_decode (
        .opcode  (imem_rsp_data[6:0]),
        .imm_src (dec_imm_s)
    );

    // A redirect suppresses the request in the same cycle so no stale address can fire.
    assign imem_req_valid = (state_r == S_REQ) && !redirect_valid && !reset;
    assign imem_req_addr  = pc_r;

    // Fetch FSM, PC and decode-side buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_REQ;
            pc_r        <= RESET_PC;
            drop_r      <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0000_0000;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= RESET_PC + 32'd4;
            if_imm_src  <= 2'b00;
`ifdef MISALIGN_CHECK_EN
            mis_pend_r    <= 1'b0;
            if_misaligned <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc_r <= redir_pc_s;
`ifdef MISALIGN_CHECK_EN
            mis_pend_r <= |redirect_pc[1:0];
`endif
            case (state_r)
                S_REQ: state_r <= S_REQ;
                S_WAIT: begin
                    // The outstanding word belongs to the old path: discard now or mark for discard.
                    if (imem_rsp_valid) begin
                        drop_r  <= 1'b0;
                        state_r <= S_REQ;
                    end else begin
                        drop_r  <= 1'b1;
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if_valid <= 1'b0;
                    state_r  <= S_REQ;
                end
                default: state_r <= S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid && drop_r) begin
                        drop_r  <= 1'b0;
                        state_r <= S_REQ;
                    end else if (imem_rsp_valid) begin
                        if_valid    <= 1'b1;
                        if_instr    <= imem_rsp_data;
                        if_pc       <= pc_r;
                        if_pc_plus4 <= pc_r + 32'd4;
                        if_imm_src  <= dec_imm_s;
`ifdef MISALIGN_CHECK_EN
                        if_misaligned <= mis_pend_r;
                        mis_pend_r    <= 1'b0;
`endif
                        state_r     <= S_HOLD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        pc_r     <= pc_r + 32'd4;
                        state_r  <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: state_r <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a transaction-level model of the fetch stage.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [1:0]  if_imm_src;
`ifdef MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_imm_src     (if_imm_src)
`ifdef MISALIGN_CHECK_EN
        ,
        .if_misaligned  (if_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: one request in flight at most, an optional decode-side buffer, next fetch PC.
    logic        m_busy, m_drop, m_buf, m_mis_pend, b_mis;
    logic [31:0] m_pc, m_req_addr, b_instr, b_pc;
    logic [1:0]  b_imm;
    logic        mem_out;

    logic [6:0] fmt_opc [6] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1101111};
    logic [1:0] fmt_sel [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [6:0] opc_pool [8] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b0110111, 7'b0110011};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_imm(input logic [31:0] w);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 6; i++) if (w[6:0] == fmt_opc[i]) r = fmt_sel[i];
        return r;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef MISALIGN_CHECK_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom();
        w[6:0] = opc_pool[$urandom_range(0, 7)];
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_drop = 1'b0; m_buf = 1'b0; m_mis_pend = 1'b0; b_mis = 1'b0;
        m_pc = RST_PC; m_req_addr = 32'h0; b_instr = 32'h0; b_pc = 32'h0; b_imm = 2'd0;
        mem_out = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        model_reset();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, RST_PC + 32'd4);
        chk("rst_if_imm_src", 32'(if_imm_src), 32'd0);
`ifdef MISALIGN_CHECK_EN
        chk("rst_if_misaligned", 32'(if_misaligned), 32'd0);
`endif
    endtask

    // One clock: drive, check outputs against the model, advance the model over the edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rqr,
                        input logic rsv, input logic [31:0] rsd, input logic ifr);
        logic rsp;
        logic exp_rv;
        rsp = rsv && mem_out;
        redirect_valid = rv; redirect_pc = rpc; imem_req_ready = rqr;
        imem_rsp_valid = rsp; imem_rsp_data = rsd; if_ready = ifr;
        #1;
        exp_rv = !rv && !m_busy && !m_buf;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_buf));
        if (m_buf) begin
            chk("if_instr", if_instr, b_instr);
            chk("if_pc", if_pc, b_pc);
            chk("if_pc_plus4", if_pc_plus4, b_pc + 32'd4);
            chk("if_imm_src", 32'(if_imm_src), 32'(b_imm));
`ifdef MISALIGN_CHECK_EN
            chk("if_misaligned", 32'(if_misaligned), 32'(b_mis));
`endif
        end
        if (rv) begin
            m_pc = tgt_of(rpc);
            m_mis_pend = |rpc[1:0];
            m_buf = 1'b0;
            if (m_busy && rsp) begin
                m_busy = 1'b0; m_drop = 1'b0;
            end else if (m_busy) begin
                m_drop = 1'b1;
            end
        end else if (m_buf && ifr) begin
            m_buf = 1'b0;
            m_pc = b_pc + 32'd4;
        end else if (m_busy && rsp) begin
            m_busy = 1'b0;
            if (m_drop) begin
                m_drop = 1'b0;
            end else begin
                m_buf = 1'b1; b_instr = rsd; b_pc = m_req_addr; b_imm = ref_imm(rsd);
                b_mis = m_mis_pend; m_mis_pend = 1'b0;
            end
        end else if (!m_busy && !m_buf && rqr) begin
            m_busy = 1'b1;
            m_req_addr = m_pc;
        end
        if (rsp) mem_out = 1'b0;
        if (imem_req_valid && imem_req_ready) mem_out = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic consume();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] opcs [4];
        logic [1:0]  sels [4];
        logic [31:0] w;
        opcs = '{32'h0000_0023, 32'h0000_0063, 32'h0000_006F, 32'h0000_0037};
        sels = '{2'd1, 2'd2, 2'd3, 2'd0};
        model_reset();
        @(posedge clk); #1;
        do_reset(3);

        // First fetch after reset.
        chk("first_addr", imem_req_addr, 32'h0);
        fetch(32'h0050_0093);
        chk("t1_instr", if_instr, 32'h0050_0093);
        chk("t1_pc", if_pc, 32'h0);
        chk("t1_pc_plus4", if_pc_plus4, 32'd4);
        chk("t1_imm", 32'(if_imm_src), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        consume();
        chk("t1_next_addr", imem_req_addr, 32'd4);

        // Redirect while waiting: the returning word is dropped.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("drop_if_valid", 32'(if_valid), 32'd0);
        chk("drop_next_addr", imem_req_addr, 32'h100);
        fetch(rand_word());
        consume();

        // Immediate-format select per opcode.
        for (int i = 0; i < 4; i++) begin
            w = $urandom();
            w[6:0] = opcs[i][6:0];
            fetch(w);
            chk("opc_imm_src", 32'(if_imm_src), 32'(sels[i]));
            consume();
        end

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h0000_0013);
        chk("wrap_pc_plus4", if_pc_plus4, 32'h0);
        consume();
        chk("wrap_next_addr", imem_req_addr, 32'h0);

`ifdef MISALIGN_CHECK_EN
        step(1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h0000_0013);
        chk("mis_first", 32'(if_misaligned), 32'd1);
        consume();
        fetch(32'h0000_0013);
        chk("mis_second", 32'(if_misaligned), 32'd0);
        consume();
`endif

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            if (c == 1500) do_reset(2);
            t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
            step($urandom_range(0, 15) == 0, t, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1, rand_word(), $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
